// File: rtl/imul_mac_client_pkg.sv
// Shared lab1 integer-multiplier message types plus the MAC client result
// message and FSM state encoding.
package imul_mac_client_pkg;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } lab1_imul_req_msg_t;

    typedef struct packed {
        logic [31:0] result;
    } lab1_imul_resp_msg_t;

    typedef struct packed {
        logic [7:0]  count;
        logic [31:0] sum;
    } imul_mac_out_msg_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } mac_state_e;

endpackage

// File: rtl/imul_mac_client_credit_ctr.sv
// Up/down counter of multiply requests in flight; gates new issues against
// MAX_OUT and tells the FSM when the pipe is (about to be) empty.
module imul_mac_credit_ctr #(
    parameter int MAX_OUT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic credit_ok,
    output logic zero,
    output logic one
);
    localparam int CW = $clog2(MAX_OUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec)
            cnt_d = cnt_q + CW'(1);
        else if (dec && !inc)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign credit_ok = (cnt_q < CW'(MAX_OUT));
    assign zero      = (cnt_q == '0);
    assign one       = (cnt_q == CW'(1));

endmodule

// File: rtl/imul_mac_client.sv
// Requester engine: issues one multiply per operand pair, sums the in-order
// products, and reports {count, sum} once per job.
module imul_mac_client
    import imul_mac_client_pkg::*;
#(
    parameter int MAX_OUT = 2,
    parameter int WIDTH   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_val,
    output logic                in_rdy,
    input  lab1_imul_req_msg_t  in_msg,
    input  logic                in_last,
    output logic                imul_req_val,
    input  logic                imul_req_rdy,
    output lab1_imul_req_msg_t  imul_req_msg,
    input  logic                imul_resp_val,
    output logic                imul_resp_rdy,
    input  lab1_imul_resp_msg_t imul_resp_msg,
    output logic                out_val,
    input  logic                out_rdy,
    output imul_mac_out_msg_t   out_msg
);
    mac_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             live_q;
    logic             credit_ok, zero, one;
    logic             issue_fire, resp_fire;

    imul_mac_credit_ctr #(.MAX_OUT(MAX_OUT)) u_credit (
        .clk       (clk),
        .reset     (reset),
        .inc       (issue_fire),
        .dec       (resp_fire),
        .credit_ok (credit_ok),
        .zero      (zero),
        .one       (one)
    );

    // live_q holds off in_rdy until the first edge after reset release.
    assign in_rdy        = live_q && (state_q == RUN) && imul_req_rdy && credit_ok;
    assign imul_req_val  = live_q && (state_q == RUN) && in_val && credit_ok;
    assign imul_req_msg  = in_msg;
    assign imul_resp_rdy = (state_q != DONE) && !zero;
    assign issue_fire    = in_val && in_rdy;
    assign resp_fire     = imul_resp_val && imul_resp_rdy;

    assign out_val = (state_q == DONE);
    assign out_msg = out_val ? imul_mac_out_msg_t'{count: cnt_q, sum: acc_q} : '0;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (resp_fire)
            acc_d = acc_q + imul_resp_msg.result;
        case (state_q)
            RUN: begin
                if (issue_fire) begin
                    cnt_d = cnt_q + 8'd1;
                    if (in_last) state_d = DRAIN;
                end
            end
            // Leave on the edge that retires the final response.
            DRAIN: begin
                if (zero || (one && resp_fire)) state_d = DONE;
            end
            DONE: begin
                if (out_rdy) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            acc_q   <= '0;
            cnt_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imul_mac_client.sv
// Directed bench for imul_mac_client with a 1-cycle in-order multiplier model
// whose responses can be held off.
module tb_imul_mac_client;
    import imul_mac_client_pkg::*;

    logic                clk;
    logic                reset;
    logic                in_val;
    logic                in_rdy;
    lab1_imul_req_msg_t  in_msg;
    logic                in_last;
    logic                imul_req_val;
    logic                imul_req_rdy;
    lab1_imul_req_msg_t  imul_req_msg;
    logic                imul_resp_val;
    logic                imul_resp_rdy;
    lab1_imul_resp_msg_t imul_resp_msg;
    logic                out_val;
    logic                out_rdy;
    imul_mac_out_msg_t   out_msg;

    int tests = 0;
    int fails = 0;

    imul_mac_client #(.MAX_OUT(2), .WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_val        (in_val),
        .in_rdy        (in_rdy),
        .in_msg        (in_msg),
        .in_last       (in_last),
        .imul_req_val  (imul_req_val),
        .imul_req_rdy  (imul_req_rdy),
        .imul_req_msg  (imul_req_msg),
        .imul_resp_val (imul_resp_val),
        .imul_resp_rdy (imul_resp_rdy),
        .imul_resp_msg (imul_resp_msg),
        .out_val       (out_val),
        .out_rdy       (out_rdy),
        .out_msg       (out_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: product visible the cycle after the request fires.
    logic [31:0] pmem [0:15];
    logic [3:0]  wp, rp;
    logic [4:0]  mcnt;
    logic        hold;
    logic        m_push, m_pop;

    assign imul_req_rdy         = 1'b1;
    assign m_push               = imul_req_val && imul_req_rdy;
    assign m_pop                = imul_resp_val && imul_resp_rdy;
    assign imul_resp_val        = (mcnt != 5'd0) && !hold;
    assign imul_resp_msg.result = pmem[rp];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wp   <= '0;
            rp   <= '0;
            mcnt <= '0;
        end else begin
            if (m_push) begin
                pmem[wp] <= imul_req_msg.a * imul_req_msg.b;
                wp       <= wp + 4'd1;
            end
            if (m_pop) rp <= rp + 4'd1;
            if (m_push && !m_pop)      mcnt <= mcnt + 5'd1;
            else if (m_pop && !m_push) mcnt <= mcnt - 5'd1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] op_a, input logic [31:0] op_b, input logic last);
        int n;
        in_val  = 1'b1;
        in_msg  = '{a: op_a, b: op_b};
        in_last = last;
        #1;
        check("req_msg_pass", imul_req_msg, in_msg);
        n = 0;
        while (!in_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 64'd0, 64'd1);
        @(negedge clk);
        in_val  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [7:0] cnt, input logic [31:0] sum);
        int n;
        n = 0;
        while (!out_val && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("result_timeout", 64'd0, 64'd1);
        check(tag, out_msg, {24'd0, cnt, sum});
        out_rdy = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
        check("out_val_clear", out_val, 64'd0);
    endtask

    int   fires;
    int   idx;
    logic seen;

    initial begin
        reset   = 1'b1;
        in_val  = 1'b0;
        in_msg  = '0;
        in_last = 1'b0;
        out_rdy = 1'b0;
        hold    = 1'b0;
        #1;
        check("rst_in_rdy",   in_rdy,        64'd0);
        check("rst_req_val",  imul_req_val,  64'd0);
        check("rst_resp_rdy", imul_resp_rdy, 64'd0);
        check("rst_out_val",  out_val,       64'd0);
        check("rst_out_msg",  out_msg,       64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rdy_before_edge", in_rdy, 64'd0);
        @(negedge clk);
        check("rdy_after_edge", in_rdy, 64'd1);

        // Basic job, also checks 2-cycle latency from last issue
        send(32'd2, 32'd3, 1'b0);
        send(32'd4, 32'd5, 1'b0);
        send(32'd6, 32'd7, 1'b1);
        check("lat_not_yet", out_val, 64'd0);
        @(negedge clk);
        check("lat_two", out_val, 64'd1);
        get_result("basic", 8'd3, 32'h44);

        // Single pair, then accumulator must be cleared for the next job
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        get_result("single", 8'd1, 32'h1);
        send(32'd3, 32'd3, 1'b1);
        get_result("acc_cleared", 8'd1, 32'h9);

        // Accumulator wraps mod 2^32
        send(32'hFFFF_FFFF, 32'd1, 1'b0);
        send(32'd2, 32'd1, 1'b1);
        get_result("acc_wrap", 8'd2, 32'h1);

        // Credit limit with responses held for 10 cycles
        hold    = 1'b1;
        fires   = 0;
        idx     = 0;
        in_val  = 1'b1;
        in_msg  = '{a: 32'd1, b: 32'd1};
        in_last = 1'b0;
        repeat (10) begin
            seen = in_rdy;
            @(negedge clk);
            if (seen) begin
                fires++;
                idx++;
                in_msg  = '{a: 32'(idx + 1), b: 32'(idx + 1)};
                in_last = (idx == 2);
            end
        end
        check("credit_fires", 64'(fires), 64'd2);
        check("credit_blocked", in_rdy, 64'd0);
        hold = 1'b0;
        #1;
        check("credit_still_blocked", in_rdy, 64'd0);
        @(negedge clk);
        check("credit_returned", in_rdy, 64'd1);
        @(negedge clk);
        in_val  = 1'b0;
        in_last = 1'b0;
        get_result("credit_job", 8'd3, 32'hE);

        // Output stall: result held, next job not accepted until out fire
        send(32'd2, 32'd2, 1'b1);
        idx = 0;
        while (!out_val && idx < 50) begin
            @(negedge clk);
            idx++;
        end
        in_val  = 1'b1;
        in_msg  = '{a: 32'd5, b: 32'd1};
        in_last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_val", out_val, 64'd1);
            check("stall_msg", out_msg, {24'd0, 8'd1, 32'd4});
            check("stall_in_rdy", in_rdy, 64'd0);
        end
        out_rdy = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
        check("stall_released", out_val, 64'd0);
        check("next_job_rdy", in_rdy, 64'd1);
        @(negedge clk);
        in_val  = 1'b0;
        in_last = 1'b0;
        get_result("after_stall", 8'd1, 32'd5);

        // Reset in the middle of a 4-pair job with requests in flight
        hold = 1'b1;
        send(32'd1, 32'd1, 1'b0);
        send(32'd1, 32'd1, 1'b0);
        in_val = 1'b1;
        in_msg = '{a: 32'd1, b: 32'd1};
        check("mid_resp_rdy", imul_resp_rdy, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_in_rdy",   in_rdy,        64'd0);
        check("mid_rst_req_val",  imul_req_val,  64'd0);
        check("mid_rst_resp_rdy", imul_resp_rdy, 64'd0);
        check("mid_rst_out_val",  out_val,       64'd0);
        check("mid_rst_out_msg",  out_msg,       64'd0);
        in_val = 1'b0;
        hold   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(32'd5, 32'd5, 1'b1);
        get_result("post_reset", 8'd1, 32'h19);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imul_mac_client.md
Name: imul_mac_client

Overview:
- Requester-side engine for the lab1 integer multiplier val/rdy protocol.
- Consumes a stream of operand pairs terminated by a last flag and issues one multiply request per pair to an attached multiplier.
- Collects the multiplier responses in order, accumulates the products, and emits one sum/count result per job.
- Sits between a job source (test source or processor) and any lab1_imul_* multiplier, and serves as the reusable initiator for those units.

Parameters:
MAX_OUT, 2, maximum multiply requests in flight without a response (1..15)
WIDTH, 32, operand/result width; fixed by lab1_imul message types

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_val  input  1  operand pair valid
in_rdy  output  1  operand pair accepted when in_val & in_rdy
in_msg  input  lab1_imul_req_msg_t (64)  operands a, b
in_last  input  1  marks final pair of a job; qualified by in_val
imul_req_val  output  1  multiply request valid
imul_req_rdy  input  1  multiplier ready
imul_req_msg  output  lab1_imul_req_msg_t (64)  equals in_msg
imul_resp_val  input  1  multiply response valid
imul_resp_rdy  output  1  client ready for response
imul_resp_msg  input  lab1_imul_resp_msg_t (32)  product low 32 bits
out_val  output  1  job result valid
out_rdy  input  1  sink ready
out_msg  output  imul_mac_out_msg_t (40)  {count[7:0], sum[31:0]}

Behaviour:
- Reset (async assert, sampled release): state=RUN, acc=0, cnt=0, outstanding=0. Outputs in_rdy=0 until first edge after release; imul_req_val=0, imul_resp_rdy=0, out_val=0, out_msg=0.
- credit_ok = (outstanding < MAX_OUT).
- RUN:
  - imul_req_val = in_val & credit_ok.
  - in_rdy = imul_req_rdy & credit_ok.
  - imul_req_msg = in_msg, passed through combinationally.
  - Issue fire = in_val & in_rdy.
  - On issue fire: cnt += 1 (wraps mod 256). If in_last, go to DRAIN.
- RUN and DRAIN: imul_resp_rdy = (outstanding != 0). On response fire: acc <= acc + imul_resp_msg.result, mod 2^32; no overflow flag.
- outstanding update:
  - +1 on issue fire only; -1 on response fire only.
  - Unchanged when both fire in the same cycle.
  - Never exceeds MAX_OUT; never underflows.
- DRAIN:
  - in_rdy=0, imul_req_val=0.
  - Go to DONE on the edge where outstanding becomes 0, counting the final response in that cycle.
  - If outstanding is already 0 on entry, DONE follows on the next edge.
- DONE:
  - out_val=1, out_msg={cnt, acc}, registered and stable while stalled.
  - in_rdy=0, imul_req_val=0, imul_resp_rdy=0.
  - On out_val & out_rdy: acc=0, cnt=0, go to RUN.
- Minimum latency, job of N pairs with a 1-cycle multiplier and MAX_OUT≥2: out_val rises 2 cycles after the last issue fire.
- Responses are assumed in order. A response arriving while outstanding==0 is not accepted (resp_rdy=0).
- Reset mid-job:
  - All counters cleared and any in-flight request abandoned.
  - The bench resets the multiplier together with the client.
- in_last on a non-fired cycle is ignored.

Decomposition:
- Shared package (lab1-imul-msgs) holds:
  - lab1_imul_req_msg_t and lab1_imul_resp_msg_t, reused as-is.
  - New imul_mac_out_msg_t {count, sum}.
  - State encoding constants RUN=2'd0, DRAIN=2'd1, DONE=2'd2.
- One sub-module: imul_mac_credit_ctr.
  - Holds the up/down outstanding counter with inc/dec inputs.
  - Outputs credit_ok and zero.
  - Width $clog2(MAX_OUT+1).
- The top level holds the FSM, accumulator and count registers.

Test Plan:
- Basic job: pairs (2,3), (4,5), (6,7 last), with IntMulBase attached and all sinks ready -> one out_msg with count=3, sum=0x00000044.
- Single-pair job: (0xFFFFFFFF,0xFFFFFFFF, last) -> count=1, sum=0x00000001. Next job (3,3 last) -> sum=0x9, confirming acc was cleared.
- Accumulator wrap: (0xFFFFFFFF,1), (2,1 last) -> sum=0x00000001, count=2.
- Credit limit: MAX_OUT=2 with a stub multiplier that holds imul_resp_val=0 for 10 cycles -> exactly 2 issue fires, then in_rdy=0 until the first response fire.
- Output stall: out_rdy=0 for 5 cycles after DONE -> out_val stays high with a stable out_msg and in_rdy=0. Pairs from the next job are accepted only after the out fire.
- Reset mid-job: assert reset after 2 of 4 pairs are issued -> all outputs go 0 asynchronously. A following job (5,5 last) -> count=1, sum=0x19.
